ahb_lite_sram_slave: RTL and testbench

//  AHB-Lite word-addressed SRAM slave. It is the design under test that the bus protocol

---
 rtl/ahb_lite_sram_slave.sv | 196 +++++++++++++++++++
 tb/tb_ahb_lite_sram_slave.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_sram_slave.sv
// ahb_lite_sram_slave
//   AHB-Lite word-organised SRAM slave with byte-lane writes, optional wait
//   states and two-cycle ERROR responses for out-of-range, oversized or
//   misaligned transfers.
//
//   Build option: define AHB_SLV_WAIT_EN to insert WAIT_CYCLES wait states in
//   every OKAY transfer. Without it, no wait counter is built and every OKAY
//   transfer completes zero-wait.
module ahb_lite_sram_slave #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [1:0]  HTRANS,
  input  logic        HREADY,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);

  // Byte-address width covering the whole array, and the word-index width.
  localparam int AW = $clog2(DEPTH * 4);
  localparam int WW = AW - 2;
  localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH * 4);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t state, state_nxt;

  logic [31:0]   mem [DEPTH];

  logic [AW-1:0] addr_p1;
  logic [2:0]    size_p1;
  logic          write_p1;

  logic          accept;
  logic          take;
  logic          illegal;
  logic          dphase_done;
  logic          commit;
  logic          rd_valid;
  logic          ready_int;
  logic          resp_int;
  logic [WW-1:0] word_idx;

  // Burst type, protection, lock, the SEQ/NONSEQ distinction and (in the
  // zero-wait build) the wait count have no effect on this slave.
  logic          unused_ok;
  assign unused_ok = &{1'b0, HTRANS[0], HBURST, HPROT, HMASTLOCK, 4'(WAIT_CYCLES)};

  // Flags a transfer this slave must answer with ERROR: outside the array,
  // wider than a word, or not naturally aligned for its size.
  function automatic logic is_illegal(input logic [31:0] a, input logic [2:0] sz);
    logic bad_align;
    bad_align = ((sz == 3'd1) && a[0]) || ((sz == 3'd2) && (a[1:0] != 2'b00));
    return (a >= BYTE_LIMIT) || (sz > 3'd2) || bad_align;
  endfunction

  // Little-endian byte-lane enables for a legal size/offset pair.
  function automatic logic [3:0] lane_mask(input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] m;
    case (sz)
      3'd0:    m = 4'b0001 << a;
      3'd1:    m = a[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Replaces the enabled byte lanes of the stored word with the bus lanes.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] res;
    res = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // Address phase: qualified transfer request from the bus.
  assign accept  = HSEL & HREADY & HTRANS[1];
  assign illegal = is_illegal(HADDR, HSIZE);
  // A request is only taken when this slave itself is ready to start a new one.
  assign take    = accept & ready_int;

`ifdef AHB_SLV_WAIT_EN
  localparam logic [3:0] WAIT_MAX = 4'(WAIT_CYCLES);

  logic [3:0] wait_cnt;

  // Counts towards WAIT_MAX and holds there instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] cnt);
    return (cnt >= WAIT_MAX) ? WAIT_MAX : cnt + 4'd1;
  endfunction

  // Wait-state counter: restarts on every taken transfer, advances in DATA.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= 4'd0;
    end else if (take) begin
      wait_cnt <= 4'd0;
    end else if (state == ST_DATA) begin
      wait_cnt <= sat_inc(wait_cnt);
    end
  end

  assign dphase_done = (wait_cnt >= WAIT_MAX);
`else
  assign dphase_done = 1'b1;
`endif

  // State register; reset abandons any data phase in flight.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and bus response outputs.
  always_comb begin
    state_nxt = state;
    ready_int = 1'b1;
    resp_int  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = illegal ? ST_ERR1 : ST_DATA;
      end
      ST_DATA: begin
        ready_int = dphase_done;
        if (dphase_done) begin
          if (accept) state_nxt = illegal ? ST_ERR1 : ST_DATA;
          else        state_nxt = ST_IDLE;
        end
      end
      ST_ERR1: begin
        ready_int = 1'b0;
        resp_int  = 1'b1;
        state_nxt = ST_ERR2;
      end
      ST_ERR2: begin
        resp_int = 1'b1;
        if (accept) state_nxt = illegal ? ST_ERR1 : ST_DATA;
        else        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // ---- address phase -> data phase boundary ----
  // Captures the address-phase attributes of each taken transfer.
  always_ff @(posedge HCLK) begin
    if (take) begin
      addr_p1  <= HADDR[AW-1:0];
      size_p1  <= HSIZE;
      write_p1 <= HWRITE;
    end
  end

  // ---- data phase ----
  assign word_idx = addr_p1[AW-1:2];
  assign commit   = (state == ST_DATA) & dphase_done &  write_p1;
  assign rd_valid = (state == ST_DATA) & dphase_done & ~write_p1;

  // Writes land on the edge that closes the data phase, so a read whose
  // address phase overlaps it already sees the new word.
  always_ff @(posedge HCLK) begin
    if (commit) begin
      mem[word_idx] <= merge_lanes(mem[word_idx], HWDATA, lane_mask(size_p1, addr_p1[1:0]));
    end
  end

  assign HRDATA    = rd_valid ? mem[word_idx] : 32'd0;
  assign HREADYOUT = ready_int;
  assign HRESP     = resp_int;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: single-slave bus, HREADY looped back
// from HREADYOUT, expected values written out by hand.
module tb_ahb_lite_sram_slave;

`ifdef AHB_SLV_WAIT_EN
  localparam logic [31:0] EXPW = 32'd1;
`else
  localparam logic [31:0] EXPW = 32'd0;
`endif

  logic        HCLK      = 1'b0;
  logic        HRESETn   = 1'b0;
  logic        HSEL      = 1'b0;
  logic [31:0] HADDR     = 32'd0;
  logic        HWRITE    = 1'b0;
  logic [2:0]  HSIZE     = 3'd0;
  logic [2:0]  HBURST    = 3'd0;
  logic [3:0]  HPROT     = 4'd0;
  logic        HMASTLOCK = 1'b0;
  logic [1:0]  HTRANS    = 2'd0;
  logic        HREADY;
  logic [31:0] HWDATA    = 32'd0;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  int n_cmp = 0;
  int n_mis = 0;

  assign HREADY = HREADYOUT;

  always #5 HCLK = ~HCLK;

  ahb_lite_sram_slave #(.DEPTH(64), .WAIT_CYCLES(1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HMASTLOCK(HMASTLOCK), .HTRANS(HTRANS), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where HREADYOUT is high.
  task automatic wait_ready(output int nw);
    nw = 0;
    while (HREADYOUT !== 1'b1 && nw < 20) begin
      nw++;
      @(negedge HCLK);
    end
    if (nw >= 20) chk("ready_timeout", {31'd0, HREADYOUT}, 32'd1);
  endtask

  // One isolated transfer; called and returns at posedge+1 with the bus idle.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic r1, output logic rf, output int nw);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'd0; HWRITE = 1'b0; HSIZE = 3'd0;
    HWDATA = wd;
    @(negedge HCLK);
    r1 = HRESP;
    wait_ready(nw);
    rd = HRDATA;
    rf = HRESP;
    @(posedge HCLK); #1;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a,
                          input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] rd; logic r1, rf; int nw;
    xfer(1'b1, a, sz, wd, rd, r1, rf, nw);
    chk({tag, "_resp"}, {31'd0, rf}, 32'd0);
    chk({tag, "_waits"}, 32'(nw), EXPW);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic r1, rf; int nw;
    xfer(1'b0, a, 3'd2, 32'd0, rd, r1, rf, nw);
    chk({tag, "_rdata"}, rd, exp);
    chk({tag, "_resp"}, {31'd0, rf}, 32'd0);
    chk({tag, "_waits"}, 32'(nw), EXPW);
  endtask

  task automatic do_err(input string tag, input logic w, input logic [31:0] a,
                        input logic [2:0] sz, input logic [31:0] wd);
    logic [31:0] rd; logic r1, rf; int nw;
    xfer(w, a, sz, wd, rd, r1, rf, nw);
    chk({tag, "_resp1"}, {31'd0, r1}, 32'd1);
    chk({tag, "_waits"}, 32'(nw), 32'd1);
    chk({tag, "_resp2"}, {31'd0, rf}, 32'd1);
    chk({tag, "_rdata"}, rd, 32'd0);
  endtask

  task automatic idle_chk(input string tag);
    @(negedge HCLK);
    chk({tag, "_ready"}, {31'd0, HREADYOUT}, 32'd1);
    chk({tag, "_resp"}, {31'd0, HRESP}, 32'd0);
    chk({tag, "_rdata"}, HRDATA, 32'd0);
    @(posedge HCLK); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw;

    // Reset held for three clocks
    HRESETn = 1'b0;
    repeat (3) begin
      @(negedge HCLK);
      chk("rst_ready", {31'd0, HREADYOUT}, 32'd1);
      chk("rst_resp", {31'd0, HRESP}, 32'd0);
      chk("rst_rdata", HRDATA, 32'd0);
    end
    @(posedge HCLK); #1;
    HRESETn = 1'b1;

    // Word write then read
    do_write("wr10", 32'h10, 3'd2, 32'hDEADBEEF);
    do_read("rd10", 32'h10, 32'hDEADBEEF);

    // Byte and halfword lanes; unused lanes carry garbage
    do_write("wr20", 32'h20, 3'd2, 32'h0000_0000);
    do_write("wb22", 32'h22, 3'd0, 32'h11AB_3344);
    do_read("rd20", 32'h20, 32'h00AB_0000);
    do_write("wr24", 32'h24, 3'd2, 32'h0000_0000);
    do_write("wh26", 32'h26, 3'd1, 32'h1234_5678);
    do_write("wb24", 32'h24, 3'd0, 32'hAAAA_AA5C);
    do_read("rd24", 32'h24, 32'h1234_005C);

    // Last legal word, then one byte past the end
    do_write("wrFC", 32'hFC, 3'd2, 32'hCAFEF00D);
    do_read("rdFC", 32'hFC, 32'hCAFEF00D);
    do_err("oor_rd", 1'b0, 32'h100, 3'd2, 32'd0);
    idle_chk("oor_after");
    do_err("oor_wr", 1'b1, 32'h100, 3'd2, 32'h0BAD0BAD);
    do_read("rdFC2", 32'hFC, 32'hCAFEF00D);

    // Misaligned and oversized writes never touch the SRAM
    do_write("wr00", 32'h00, 3'd2, 32'h11223344);
    do_err("mis_word", 1'b1, 32'h02, 3'd2, 32'h55667788);
    do_err("mis_half", 1'b1, 32'h01, 3'd1, 32'h99999999);
    do_err("big_size", 1'b1, 32'h00, 3'd3, 32'h77777777);
    do_read("rd00", 32'h00, 32'h11223344);

    // IDLE and BUSY while selected, then NONSEQ while unselected
    HWDATA = 32'hFFFF_FFFF;
    HSEL = 1'b1; HTRANS = 2'b00; HWRITE = 1'b1; HADDR = 32'h0; HSIZE = 3'd2;
    idle_chk("sel_idle");
    HTRANS = 2'b01;
    idle_chk("sel_busy");
    HSEL = 1'b0; HTRANS = 2'b10;
    idle_chk("unsel_nseq");
    HTRANS = 2'b00; HWRITE = 1'b0;
    idle_chk("unsel_after");
    do_read("rd00b", 32'h00, 32'h11223344);

    // Back-to-back write then read of the same word
    do_write("wr30", 32'h30, 3'd2, 32'h0000_0000);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h30; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HWDATA = 32'hA5A5_A5A5; HWRITE = 1'b0;
    @(negedge HCLK);
    wait_ready(nw);
    chk("raw_wr_waits", 32'(nw), EXPW);
    chk("raw_wr_resp", {31'd0, HRESP}, 32'd0);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0;
    @(negedge HCLK);
    wait_ready(nw);
    chk("raw_rd_rdata", HRDATA, 32'hA5A5_A5A5);
    chk("raw_rd_waits", 32'(nw), EXPW);
    @(posedge HCLK); #1;

    // Reset in the middle of a write data phase drops the write
    do_write("wr40", 32'h40, 3'd2, 32'h12345678);
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HADDR = 32'h0; HWRITE = 1'b0;
    HWDATA = 32'h0BADF00D;
    HRESETn = 1'b0;
    @(negedge HCLK);
    chk("rstmid_ready", {31'd0, HREADYOUT}, 32'd1);
    chk("rstmid_resp", {31'd0, HRESP}, 32'd0);
    chk("rstmid_rdata", HRDATA, 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    do_read("rd40", 32'h40, 32'h12345678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
